// File: rtl/spw_switch_if.sv
// rtl/spw_switch_if.sv - SpaceWire crossbar channel bundle (rx lanes in, tx lanes out, error count)
interface spw_switch_if #(
    parameter int COUNT = 8
);
    logic [COUNT*8-1:0] rx_data;
    logic [COUNT-1:0]   rx_eop;
    logic [COUNT-1:0]   rx_valid;
    logic [COUNT-1:0]   rx_ready;
    logic [COUNT*8-1:0] tx_data;
    logic [COUNT-1:0]   tx_eop;
    logic [COUNT-1:0]   tx_valid;
    logic [COUNT-1:0]   tx_ready;
    logic [15:0]        err_cnt;

    modport master (
        output rx_data, rx_eop, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_eop, tx_valid, err_cnt
    );

    modport slave (
        input  rx_data, rx_eop, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_eop, tx_valid, err_cnt
    );
endinterface

// File: rtl/spw_switch.sv
// rtl/spw_switch.sv - path-addressed packet crossbar with per-output round-robin arbitration
module spw_switch #(
    parameter int COUNT = 8,
    parameter int AW    = $clog2(COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    spw_switch_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FWD, S_DROP} state_t;

    // per-input parser state
    state_t           r_state     [COUNT];
    state_t           w_state_nxt [COUNT];
    logic [AW-1:0]    r_dst       [COUNT];
    logic [AW-1:0]    w_dst_nxt   [COUNT];
    logic [COUNT-1:0] w_rx_ready;
    logic [COUNT-1:0] w_release;

    // per-output ownership and round-robin pointer
    logic [COUNT-1:0] r_own_vld;
    logic [AW-1:0]    r_own_idx [COUNT];
    logic [AW-1:0]    r_ptr     [COUNT];
    logic [COUNT-1:0] w_gnt_vld;
    logic [AW-1:0]    w_gnt_idx [COUNT];

    logic [COUNT*8-1:0] w_tx_data;
    logic [COUNT-1:0]   w_tx_eop;
    logic [COUNT-1:0]   w_tx_valid;

    logic [15:0] r_err_cnt;
    logic [4:0]  w_err_inc;
    logic [17:0] w_err_sum;

    // each free output picks the first requester at or after its pointer
    always_comb begin : arb_comb
        int idx;
        idx = 0;
        for (int o = 0; o < COUNT; o++) begin
            w_gnt_vld[o] = 1'b0;
            w_gnt_idx[o] = '0;
            if (!r_own_vld[o]) begin
                for (int k = 0; k < COUNT; k++) begin
                    idx = (int'(r_ptr[o]) + k) % COUNT;
                    if (!w_gnt_vld[o] && r_state[idx] == S_REQ && r_dst[idx] == AW'(o)) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt_idx[o] = AW'(idx);
                    end
                end
            end
        end
    end

    // input parser: header decode, request, pass-through, discard
    always_comb begin
        w_err_inc = '0;
        for (int i = 0; i < COUNT; i++) begin
            w_state_nxt[i] = r_state[i];
            w_dst_nxt[i]   = r_dst[i];
            w_rx_ready[i]  = 1'b0;
            w_release[i]   = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    w_rx_ready[i] = 1'b1;
                    if (bus.rx_valid[i]) begin
                        if (bus.rx_eop[i]) begin
                            w_err_inc = w_err_inc + 5'd1;
                        end else if ({24'd0, bus.rx_data[8*i +: 8]} >= 32'(COUNT)) begin
                            w_state_nxt[i] = S_DROP;
                        end else begin
                            w_dst_nxt[i]   = bus.rx_data[8*i +: AW];
                            w_state_nxt[i] = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (w_gnt_vld[r_dst[i]] && w_gnt_idx[r_dst[i]] == AW'(i)) begin
                        w_state_nxt[i] = S_FWD;
                    end
                end
                S_FWD: begin
                    w_rx_ready[i] = bus.tx_ready[r_dst[i]];
                    if (bus.rx_valid[i] && bus.tx_ready[r_dst[i]] && bus.rx_eop[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_release[i]   = 1'b1;
                    end
                end
                default: begin
                    w_rx_ready[i] = 1'b1;
                    if (bus.rx_valid[i] && bus.rx_eop[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_err_inc      = w_err_inc + 5'd1;
                    end
                end
            endcase
            if (rst) begin
                w_rx_ready[i] = 1'b0;
            end
        end
    end

    // owned outputs mirror their owner's rx lane; everything else idles at zero
    always_comb begin
        w_tx_data  = '0;
        w_tx_eop   = '0;
        w_tx_valid = '0;
        for (int o = 0; o < COUNT; o++) begin
            if (r_own_vld[o] && !rst) begin
                w_tx_data[8*o +: 8] = bus.rx_data[8*int'(r_own_idx[o]) +: 8];
                w_tx_eop[o]         = bus.rx_eop[r_own_idx[o]];
                w_tx_valid[o]       = bus.rx_valid[r_own_idx[o]];
            end
        end
    end

    assign w_err_sum = {2'b00, r_err_cnt} + 18'(w_err_inc);

    // state, ownership, pointers and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COUNT; i++) begin
                r_state[i]   <= S_IDLE;
                r_dst[i]     <= '0;
                r_own_idx[i] <= '0;
                r_ptr[i]     <= '0;
            end
            r_own_vld <= '0;
            r_err_cnt <= '0;
        end else begin
            for (int i = 0; i < COUNT; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_dst[i]   <= w_dst_nxt[i];
            end
            for (int o = 0; o < COUNT; o++) begin
                if (w_gnt_vld[o]) begin
                    r_own_vld[o] <= 1'b1;
                    r_own_idx[o] <= w_gnt_idx[o];
                    r_ptr[o]     <= AW'((int'(w_gnt_idx[o]) + 1) % COUNT);
                end else if (r_own_vld[o] && w_release[r_own_idx[o]]) begin
                    r_own_vld[o] <= 1'b0;
                end
            end
            r_err_cnt <= (w_err_sum > 18'h0FFFF) ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.tx_data  = w_tx_data;
    assign bus.tx_eop   = w_tx_eop;
    assign bus.tx_valid = w_tx_valid;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_spw_switch.sv
// tb/tb_spw_switch.sv - scoreboard bench for spw_switch with randomized traffic
module tb_spw_switch;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spw_switch_if #(.COUNT(N)) bus ();
    spw_switch #(.COUNT(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // pend entry: {is_header, eop, data}; exp entry: {dst[3:0], eop, data}
    logic [9:0]  pend  [N][$];
    logic [12:0] exp_q [N][$];
    logic [7:0]  tmp_pl[$];
    int cur_src [N];
    int hdr_edge[N];
    int src_log4[$];
    int edges5[$];
    int model_err = 0;
    bit bubbles = 0, bp_chk = 0, rdy0_chk = 0;
    int txr_mode = 0;
    int bp_k = 0;
    int exp_order[5] = '{1, 3, 6, 7, 0};

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic err_inc();
        if (model_err < 65535) model_err++;
    endtask

    // expected behaviour: empty or badly addressed packets count as errors, others route payload to hdr
    task automatic push_pkt(input int src, input int hdr);
        bit last;
        if (tmp_pl.size() == 0) begin
            pend[src].push_back({2'b11, 8'(hdr)});
            err_inc();
        end else begin
            pend[src].push_back({2'b10, 8'(hdr)});
            for (int k = 0; k < tmp_pl.size(); k++) begin
                last = (k == tmp_pl.size() - 1);
                pend[src].push_back({1'b0, last, tmp_pl[k]});
                if (hdr < N) exp_q[src].push_back({4'(hdr), last, tmp_pl[k]});
            end
            if (hdr >= N) err_inc();
        end
        tmp_pl.delete();
    endtask

    task automatic wait_drain(input int budget);
        int t;
        bit busy;
        t = 0;
        busy = 1;
        while (busy && t < budget) begin
            @(posedge clk); #2;
            t++;
            busy = 0;
            for (int i = 0; i < N; i++)
                if (pend[i].size() != 0 || exp_q[i].size() != 0 || cur_src[i] >= 0) busy = 1;
        end
        chk("drain_timeout", busy, 0);
        if (busy) begin
            for (int i = 0; i < N; i++) begin
                pend[i].delete();
                exp_q[i].delete();
            end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_err = 0;
    endtask

    // stimulus engine: presents queued bytes, drives tx_ready, retires accepted bytes
    initial begin
        bus.rx_data  = '0;
        bus.rx_eop   = '0;
        bus.rx_valid = '0;
        bus.tx_ready = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
                    bus.rx_valid[i]        = 1'b1;
                    bus.rx_data[8*i +: 8]  = pend[i][0][7:0];
                    bus.rx_eop[i]          = pend[i][0][8];
                end else begin
                    bus.rx_valid[i]        = 1'b0;
                    bus.rx_data[8*i +: 8]  = 8'h00;
                    bus.rx_eop[i]          = 1'b0;
                end
            end
            for (int o = 0; o < N; o++) begin
                case (txr_mode)
                    0:       bus.tx_ready[o] = 1'b1;
                    1:       bus.tx_ready[o] = ($urandom_range(0, 3) != 0);
                    default: bus.tx_ready[o] = (o != 1) || (bp_k % 4 == 0) || (bp_k % 4 == 3);
                endcase
            end
            bp_k++;
            @(negedge clk);
            if (rdy0_chk && !rst) chk("rx_ready0_during_drop", bus.rx_ready[0], 1);
            if (bp_chk && pend[0].size() > 0 && !pend[0][0][9] && cyc >= hdr_edge[0] + 1)
                chk("rx_ready0_mirrors_tx_ready1", bus.rx_ready[0], bus.tx_ready[1]);
            for (int i = 0; i < N; i++) begin
                if (bus.rx_valid[i] && bus.rx_ready[i] && pend[i].size() > 0) begin
                    if (pend[i][0][9]) hdr_edge[i] = cyc + 1;
                    void'(pend[i].pop_front());
                end
            end
        end
    end

    // monitor: matches each tx transfer to the scoreboard entry of the packet's source
    initial begin : monitor
        logic [7:0]  d;
        logic        e;
        logic [12:0] ex;
        int          s;
        for (int o = 0; o < N; o++) cur_src[o] = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid_eop_ready", {bus.tx_valid, bus.tx_eop, bus.rx_ready}, 0);
                chk("rst_tx_data", bus.tx_data, 0);
                for (int o = 0; o < N; o++) cur_src[o] = -1;
            end else begin
                for (int o = 0; o < N; o++) begin
                    if (bus.tx_valid[o] && bus.tx_ready[o]) begin
                        d = bus.tx_data[8*o +: 8];
                        e = bus.tx_eop[o];
                        s = cur_src[o];
                        if (s < 0) begin
                            for (int k = 0; k < N; k++)
                                if (s < 0 && exp_q[k].size() > 0 && exp_q[k][0][12:9] == 4'(o) && exp_q[k][0][7:0] == d)
                                    s = k;
                            if (s < 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL tx_unexpected lane %0d: got data %02h eop %0b, required no transfer", o, d, e);
                            end else if (o == 4) begin
                                src_log4.push_back(s);
                            end
                        end else if (exp_q[s].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL tx_overrun lane %0d: got data %02h, required end of packet from input %0d", o, d, s);
                            s = -1;
                            cur_src[o] = -1;
                        end
                        if (s >= 0) begin
                            ex = exp_q[s].pop_front();
                            chk($sformatf("tx_lane%0d_byte_from_in%0d", o, s), {4'(o), e, d}, ex);
                            if (o == 5) edges5.push_back(cyc + 1);
                            cur_src[o] = e ? -1 : s;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len, dst;
        do_reset();
        @(negedge clk);
        chk("reset_err_cnt", bus.err_cnt, 0);
        chk("reset_rx_ready", bus.rx_ready, 8'hFF);
        chk("reset_tx_valid", bus.tx_valid, 0);

        // basic route 2 -> 5
        edges5.delete();
        tmp_pl.push_back(8'hA1); tmp_pl.push_back(8'hA2); tmp_pl.push_back(8'hA3);
        push_pkt(2, 5);
        wait_drain(200);
        chk("basic_byte_count", edges5.size(), 3);
        if (edges5.size() == 3) begin
            chk("basic_header_to_payload", edges5[0] - hdr_edge[2], 2);
            chk("basic_consecutive", edges5[2] - edges5[0], 2);
        end
        chk("basic_err_cnt", bus.err_cnt, model_err);

        // invalid address then empty packet on input 0
        rdy0_chk = 1;
        tmp_pl.push_back(8'h11); tmp_pl.push_back(8'h22);
        push_pkt(0, 8'h20);
        push_pkt(0, 8'h07);
        wait_drain(200);
        rdy0_chk = 0;
        chk("invalid_err_cnt", bus.err_cnt, 2);

        // contention on output 4, then pointer probe with inputs 0 and 7
        do_reset();
        src_log4.delete();
        for (int b = 0; b < 4; b++) tmp_pl.push_back(8'(8'h10 + b));
        push_pkt(1, 4);
        for (int b = 0; b < 4; b++) tmp_pl.push_back(8'(8'h30 + b));
        push_pkt(3, 4);
        for (int b = 0; b < 4; b++) tmp_pl.push_back(8'(8'h60 + b));
        push_pkt(6, 4);
        wait_drain(400);
        for (int b = 0; b < 4; b++) tmp_pl.push_back(8'(8'h01 + b));
        push_pkt(0, 4);
        for (int b = 0; b < 4; b++) tmp_pl.push_back(8'(8'h70 + b));
        push_pkt(7, 4);
        wait_drain(400);
        chk("contention_packet_count", src_log4.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("contention_order_%0d", k), (k < src_log4.size()) ? src_log4[k] : -1, exp_order[k]);

        // backpressure 0 -> 1 with tx_ready[1] pattern 1,0,0,1
        txr_mode = 2;
        bp_k = 0;
        bp_chk = 1;
        for (int b = 0; b < 8; b++) tmp_pl.push_back(8'($urandom_range(0, 255)));
        push_pkt(0, 1);
        wait_drain(400);
        bp_chk = 0;
        txr_mode = 0;

        // reset in the middle of a packet: A2 becomes a bad header
        pend[2].push_back({2'b10, 8'h05});
        pend[2].push_back({2'b00, 8'hA1});
        pend[2].push_back({2'b00, 8'hA2});
        pend[2].push_back({2'b01, 8'hA3});
        exp_q[2].push_back({4'd5, 1'b0, 8'hA1});
        r = 0;
        while (pend[2].size() != 2 && r < 100) begin
            @(posedge clk); #2;
            r++;
        end
        chk("rst_mid_reached_payload", pend[2].size(), 2);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        model_err = 0;
        err_inc();
        wait_drain(200);
        chk("rst_mid_err_cnt", bus.err_cnt, model_err);

        // randomized traffic with bubbles and random backpressure
        bubbles = 1;
        txr_mode = 1;
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 12; p++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    push_pkt(s, $urandom_range(0, 255));
                end else if (r == 1) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) tmp_pl.push_back(8'($urandom_range(0, 255)));
                    push_pkt(s, $urandom_range(N, 255));
                end else begin
                    dst = $urandom_range(0, N - 1);
                    len = $urandom_range(1, 6);
                    tmp_pl.push_back({4'(s), 4'($urandom_range(0, 15))});
                    for (int b = 1; b < len; b++) tmp_pl.push_back(8'($urandom_range(0, 255)));
                    push_pkt(s, dst);
                end
            end
        end
        wait_drain(20000);
        bubbles = 0;
        txr_mode = 0;
        chk("random_err_cnt", bus.err_cnt, model_err);

        // saturation: 65535 empty packets spread over all inputs, then one more
        do_reset();
        for (int k = 0; k < 65535; k++) push_pkt(k % N, $urandom_range(0, 255));
        wait_drain(12000);
        chk("sat_preload_err_cnt", bus.err_cnt, 16'hFFFF);
        push_pkt(3, 0);
        wait_drain(200);
        chk("sat_hold_err_cnt", bus.err_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
